fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined RV32I core. It is the producing end of the control path.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Registers the returned instruction into the IF/ID register and presents op/funct3/funct7_5 to the control unit.
- Consumes PCSrc and the branch/jump target back from execute to redirect and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on reset and flush (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request; held high until imem_ack
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack
- imem_ack  input  1  response valid this cycle, imem_rdata qualified by it
- imem_rdata  input  32  instruction word
- pc_src  input  1  redirect from execute ((branch&zero)|jump)
- pc_target  input  32  redirect target; bits [1:0] ignored (forced 00)
- stall  input  1  hold IF/ID (load-use hazard from decode)
- id_valid  output  1  IF/ID holds a real instruction
- id_instr  output  32  IF/ID instruction
- id_pc  output  32  PC of id_instr
- id_pc_plus4  output  32  id_pc+4, wraps mod 2^32
- op  output  7  id_instr[6:0]
- funct3  output  3  id_instr[14:12]
- funct7_5  output  1  id_instr[30]

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0.
  - Skid buffer empty.
- op/funct3/funct7_5 are combinational slices of id_instr. No other combinational paths from inputs to outputs except imem_addr=pc.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: one cycle after reset release, go to REQ. imem_req=0.
- REQ: imem_req=1, imem_addr=pc.
  - ack & !stall & !pc_src:
    - IF/ID <= {1, imem_rdata, pc, pc+4}; pc <= pc+4; stay in REQ.
    - Zero-wait memory sustains 1 instr/cycle.
  - ack & stall & !pc_src:
    - rdata/pc go into the skid buffer; IF/ID unchanged; pc <= pc+4; go to HOLD.
  - !ack & !stall: id_valid <= 0 (bubble); id_instr/id_pc unchanged.
  - !ack & stall: IF/ID held.
- HOLD: imem_req=0; IF/ID held while stall=1.
  - When stall=0: IF/ID <= skid contents, valid=1; skid is emptied; go to REQ.
- Redirect (pc_src=1) has priority over stall and ack in every non-IDLE state:
  - pc <= {pc_target[31:2],2'b00}.
  - IF/ID flushed: id_valid=0, id_instr=NOP_INSTR. id_pc/id_pc_plus4 are don't-care but must hold.
  - Skid buffer is emptied.
  - REQ with ack in the same cycle: data discarded; stay in REQ at the new pc next cycle.
  - REQ without ack: a request is outstanding and cannot be withdrawn, so go to DROP.
  - HOLD: go to REQ.
- DROP: imem_req held high at the old address until ack; data discarded; then go to REQ with the redirected pc.
  - A further pc_src in DROP updates pc only.
- A pc_src pulse is honoured once per cycle it is high. Execute guarantees a single-cycle pulse.
- pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error.
- imem_ack while imem_req=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_count[31:0] and flush_count[31:0], both reset to 0.
  - fetch_count increments on each instruction written into IF/ID with valid=1.
  - flush_count increments on each cycle pc_src=1.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, zero-wait memory returning addr-dependent words:
  - imem_addr sequence 0,4,8,C on consecutive cycles.
  - id_valid=1 from the 3rd cycle after reset release.
  - id_pc tracks the address with 1-cycle lag.
  - id_instr=32'h0020_8133 gives op=7'h33, funct3=0, funct7_5=0.
- Memory with 2-cycle ack latency:
  - id_valid toggles 1,0,1,0.
  - imem_addr stable during each wait.
  - No instruction duplicated or lost.
- stall=1 for 3 cycles with ack arriving during stall:
  - IF/ID frozen; imem_req=0 in HOLD.
  - After stall drops, the buffered word appears next cycle, then fetch resumes at +4.
- pc_src=1, pc_target=32'h0000_0103 with ack in the same cycle:
  - Next imem_addr=32'h100.
  - id_valid=0, id_instr=32'h0000_0013.
- pc_src while a request is unacked (ack 3 cycles later):
  - DROP keeps the old address until ack; that word is never written to IF/ID.
  - Next request goes to the target.
- Assert rst mid-stream in HOLD:
  - Outputs return to reset values asynchronously.
  - Fetch restarts at RESET_PC.
  - With FETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch: PC, imem req/ack, skid buffer, IF/ID reg.
//            Optional macro FETCH_PERF_CNT_EN adds fetch/flush counters.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;

    logic        w_req;
    logic        w_ld_mem;
    logic        w_ld_skid;
    logic        w_bubble;
    logic        w_flush;
    logic        w_fill_skid;
    logic        w_pc_inc;
    logic        w_redirect;
    logic        w_enter_drop;
    logic        w_unused_tgt;

    assign w_unused_tgt = ^pc_target[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_req        = 1'b0;
        w_ld_mem     = 1'b0;
        w_ld_skid    = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_fill_skid  = 1'b0;
        w_pc_inc     = 1'b0;
        w_redirect   = 1'b0;
        w_enter_drop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_REQ;
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (pc_src) begin
                    w_redirect = 1'b1;
                    w_flush    = 1'b1;
                    // An unacked request cannot be withdrawn; its data must be swallowed.
                    if (!imem_ack) begin
                        w_enter_drop = 1'b1;
                        w_next       = ST_DROP;
                    end
                end else if (imem_ack) begin
                    w_pc_inc = 1'b1;
                    if (stall) begin
                        w_fill_skid = 1'b1;
                        w_next      = ST_HOLD;
                    end else begin
                        w_ld_mem = 1'b1;
                    end
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (pc_src) begin
                    w_redirect = 1'b1;
                    w_flush    = 1'b1;
                    w_next     = ST_REQ;
                end else if (!stall) begin
                    w_ld_skid = 1'b1;
                    w_next    = ST_REQ;
                end
            end
            ST_DROP: begin
                w_req = 1'b1;
                if (pc_src) begin
                    w_redirect = 1'b1;
                end
                if (imem_ack) begin
                    w_next = ST_REQ;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_drop_addr  <= 32'h0;
            r_skid_instr <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_id_valid   <= 1'b0;
            r_id_instr   <= NOP_INSTR;
            r_id_pc      <= 32'h0;
            r_id_pc4     <= 32'h0;
        end else begin
            if (w_redirect) begin
                r_pc <= {pc_target[31:2], 2'b00};
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_enter_drop) begin
                r_drop_addr <= r_pc;
            end

            if (w_fill_skid) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_pc;
            end

            // id_pc/id_pc_plus4 deliberately keep their value on flush and bubble.
            if (w_flush) begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
            end else if (w_ld_mem) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rdata;
                r_id_pc    <= r_pc;
                r_id_pc4   <= r_pc + 32'd4;
            end else if (w_ld_skid) begin
                r_id_valid <= 1'b1;
                r_id_instr <= r_skid_instr;
                r_id_pc    <= r_skid_pc;
                r_id_pc4   <= r_skid_pc + 32'd4;
            end else if (w_bubble) begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc4;
    assign op          = r_id_instr[6:0];
    assign funct3      = r_id_instr[14:12];
    assign funct7_5    = r_id_instr[30];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_ld_mem || w_ld_skid) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (pc_src) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign flush_count = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed vector table, async-reset sequence and randomized run
//            against a queue-based reference model for fetch_stage.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0020_8133;
    localparam logic [31:0] I1  = 32'h40A5_D2B3;
    localparam logic [31:0] I2  = 32'h1234_5678;
    localparam logic [31:0] I3  = 32'h8765_4321;
    localparam logic [31:0] I4  = 32'h5555_6666;
    localparam logic [31:0] I5  = 32'hC0DE_F00D;
    localparam logic [31:0] I6  = 32'h0BAD_CAFE;
    localparam logic [31:0] I7  = 32'h7777_1111;
    localparam logic [31:0] I8  = 32'hDEAD_0001;
    localparam logic [31:0] I9  = 32'h2468_ACE0;
    localparam logic [31:0] I10 = 32'h1357_9BDF;
    localparam logic [31:0] JNK = 32'hDEAD_BEEF;
    localparam int          NVEC = 24;
    localparam int          NRAND = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .stall      (stall),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4),
        .op         (op),
        .funct3     (funct3),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
        .flush_count(flush_count),
`endif
        .funct7_5   (funct7_5)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        src;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    vec_t tbl [NVEC];

    // Reference model: fetch progress, pending discard, buffered word, IF/ID contents.
    bit          m_started;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    ent_t        m_buf[$];
    logic        m_v;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ip4;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ifid(input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                            input logic [31:0] ep4);
        chk("id_valid", {31'h0, id_valid}, {31'h0, ev});
        chk("id_instr", id_instr, ei);
        chk("id_pc", id_pc, ep);
        chk("id_pc_plus4", id_pc_plus4, ep4);
        chk("op", {25'h0, op}, {25'h0, ei[6:0]});
        chk("funct3", {29'h0, funct3}, {29'h0, ei[14:12]});
        chk("funct7_5", {31'h0, funct7_5}, {31'h0, ei[30]});
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_drop    = 1'b0;
        m_pc      = 32'h0;
        m_daddr   = 32'h0;
        m_buf.delete();
        m_v       = 1'b0;
        m_instr   = NOP;
        m_ipc     = 32'h0;
        m_ip4     = 32'h0;
        m_fetch   = 32'h0;
        m_flush   = 32'h0;
    endtask

    task automatic model_step(input logic a, input logic [31:0] rd, input logic st,
                              input logic src, input logic [31:0] tg);
        ent_t e;
        if (src) m_flush = m_flush + 32'd1;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (src) begin
            if (m_drop) begin
                if (a) m_drop = 1'b0;
            end else if (m_buf.size() == 0 && !a) begin
                m_drop  = 1'b1;
                m_daddr = m_pc;
            end
            m_pc    = tg & 32'hFFFF_FFFC;
            m_v     = 1'b0;
            m_instr = NOP;
            m_buf.delete();
        end else if (m_drop) begin
            if (a) m_drop = 1'b0;
        end else if (m_buf.size() != 0) begin
            if (!st) begin
                e       = m_buf.pop_front();
                m_v     = 1'b1;
                m_instr = e.instr;
                m_ipc   = e.pc;
                m_ip4   = e.pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end
        end else if (a) begin
            if (st) begin
                e.instr = rd;
                e.pc    = m_pc;
                m_buf.push_back(e);
            end else begin
                m_v     = 1'b1;
                m_instr = rd;
                m_ipc   = m_pc;
                m_ip4   = m_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_v = 1'b0;
        end
    endtask

    initial begin
        //               ack rdata stl src tgt            req addr          v  instr pc            p4
        tbl[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, NOP, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, I0,    1'b0, 1'b0, 32'h0,       1'b1, 32'h0,        1'b0, NOP, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, I1,    1'b0, 1'b0, 32'h0,       1'b1, 32'h4,        1'b1, I0,  32'h0,        32'h4};
        tbl[3]  = '{1'b1, I2,    1'b0, 1'b0, 32'h0,       1'b1, 32'h8,        1'b1, I1,  32'h4,        32'h8};
        tbl[4]  = '{1'b1, I3,    1'b0, 1'b0, 32'h0,       1'b1, 32'hC,        1'b1, I2,  32'h8,        32'hC};
        tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h10,       1'b1, I3,  32'hC,        32'h10};
        tbl[6]  = '{1'b1, I4,    1'b0, 1'b0, 32'h0,       1'b1, 32'h10,       1'b0, I3,  32'hC,        32'h10};
        tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h14,       1'b1, I4,  32'h10,       32'h14};
        tbl[8]  = '{1'b1, I5,    1'b0, 1'b0, 32'h0,       1'b1, 32'h14,       1'b0, I4,  32'h10,       32'h14};
        tbl[9]  = '{1'b1, I6,    1'b1, 1'b0, 32'h0,       1'b1, 32'h18,       1'b1, I5,  32'h14,       32'h18};
        tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, I5,  32'h14,       32'h18};
        tbl[11] = '{1'b1, JNK,   1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, I5,  32'h14,       32'h18};
        tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, I5,  32'h14,       32'h18};
        tbl[13] = '{1'b1, I7,    1'b0, 1'b0, 32'h0,       1'b1, 32'h1C,       1'b1, I6,  32'h18,       32'h1C};
        tbl[14] = '{1'b1, I8,    1'b0, 1'b1, 32'h103,     1'b1, 32'h20,       1'b1, I7,  32'h1C,       32'h20};
        tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, NOP, 32'h1C,       32'h20};
        tbl[16] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h202,     1'b1, 32'h100,      1'b0, NOP, 32'h1C,       32'h20};
        tbl[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, NOP, 32'h1C,       32'h20};
        tbl[18] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, NOP, 32'h1C,       32'h20};
        tbl[19] = '{1'b1, JNK,   1'b0, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, NOP, 32'h1C,       32'h20};
        tbl[20] = '{1'b1, I9,    1'b0, 1'b0, 32'h0,       1'b1, 32'h200,      1'b0, NOP, 32'h1C,       32'h20};
        tbl[21] = '{1'b1, JNK,   1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h204,     1'b1, I9,  32'h200,      32'h204};
        tbl[22] = '{1'b1, I10,   1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFFFFFC, 1'b0, NOP, 32'h200,      32'h204};
        tbl[23] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,        1'b1, I10, 32'hFFFFFFFC, 32'h0};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            imem_ack   = tbl[k].ack;
            imem_rdata = tbl[k].rdata;
            stall      = tbl[k].stl;
            pc_src     = tbl[k].src;
            pc_target  = tbl[k].tgt;
            #1;
            chk("imem_req", {31'h0, imem_req}, {31'h0, tbl[k].e_req});
            if (tbl[k].e_req) chk("imem_addr", imem_addr, tbl[k].e_addr);
            chk_ifid(tbl[k].e_v, tbl[k].e_instr, tbl[k].e_pc, tbl[k].e_p4);
            @(negedge clk);
        end
        pc_src   = 1'b0;
        imem_ack = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd10);
        chk("flush_count", flush_count, 32'd3);
`endif

        // Enter HOLD, then hit reset asynchronously between clock edges.
        imem_ack   = 1'b1;
        imem_rdata = I3;
        stall      = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk_ifid(1'b0, NOP, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_count", fetch_count, 32'h0);
        chk("rst_flush_count", flush_count, 32'h0);
`endif
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        #1;
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        begin
            int   lat_rem;
            logic prev_src;
            lat_rem  = -1;
            prev_src = 1'b0;
            for (int n = 0; n < NRAND; n++) begin
                logic        a, st, src;
                logic [31:0] rd, tg;
                logic        exp_req;
                #1;
                exp_req = m_started && (m_buf.size() == 0);
                chk("rnd_imem_req", {31'h0, imem_req}, {31'h0, exp_req});
                if (exp_req) chk("rnd_imem_addr", imem_addr, m_drop ? m_daddr : m_pc);
                chk_ifid(m_v, m_instr, m_ipc, m_ip4);
`ifdef FETCH_PERF_CNT_EN
                chk("rnd_fetch_count", fetch_count, m_fetch);
                chk("rnd_flush_count", flush_count, m_flush);
`endif
                rd  = $urandom;
                st  = ($urandom % 4) == 0;
                src = !prev_src && (($urandom % 12) == 0);
                tg  = $urandom;
                if (($urandom % 4) == 0) tg = 32'hFFFF_FFF0 | ($urandom % 16);
                if (imem_req) begin
                    if (lat_rem < 0) lat_rem = $urandom % 3;
                    a = (lat_rem == 0);
                    if (a) lat_rem = -1;
                    else   lat_rem = lat_rem - 1;
                end else begin
                    lat_rem = -1;
                    a = ($urandom % 4) == 0;
                end
                imem_ack   = a;
                imem_rdata = rd;
                stall      = st;
                pc_src     = src;
                pc_target  = tg;
                prev_src   = src;
                model_step(a, rd, st, src, tg);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
